mem_port_arbiter: RTL and testbench

//  Shares one single-ported 64-bit memory between the instruction-fetch stage (read-only)
//  and the data/MEM stage (read/write). Arbitrates per access, sequences the memory
//  req/ack handshake, returns data and a one-cycle ready pulse to the winning requester.

---
 rtl/mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported 64-bit memory between instruction fetch
// (read-only) and the data stage (read/write). Data wins contested cycles until it has
// taken MAX_D_STREAK contested grants in a row; fetch is then forced in.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES
// BUSY cycles without mem_ack (response carries err=1, rdata=0).
module mem_port_arbiter #(
  parameter int unsigned MAX_D_STREAK   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  // Instruction fetch port
  input  logic        i_if_req,
  input  logic [63:0] i_if_addr,
  output logic        o_if_ready,
  output logic [31:0] o_if_rdata,
  output logic        o_if_err,
  // Data port
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [63:0] i_d_addr,
  input  logic [63:0] i_d_wdata,
  input  logic [7:0]  i_d_wmask,
  output logic        o_d_ready,
  output logic [63:0] o_d_rdata,
  output logic        o_d_err,
  // Memory port
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [63:0] o_mem_addr,
  output logic [63:0] o_mem_wdata,
  output logic [7:0]  o_mem_wmask,
  input  logic        i_mem_ack,
  input  logic [63:0] i_mem_rdata
);

  localparam int unsigned StreakW = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(MAX_D_STREAK);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD, StResp} state_e;

  state_e             r_state,     w_state_nxt;
  logic [StreakW-1:0] r_streak,    w_streak_nxt;
  logic               r_mem_req,   w_mem_req_nxt;
  logic               r_mem_we,    w_mem_we_nxt;
  logic [63:0]        r_mem_addr,  w_mem_addr_nxt;
  logic [63:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]         r_mem_wmask, w_mem_wmask_nxt;
  logic               r_if_sel_hi, w_if_sel_hi_nxt;  // fetch wants the upper 32-bit half
  logic               r_if_ready,  w_if_ready_nxt;
  logic [31:0]        r_if_rdata,  w_if_rdata_nxt;
  logic               r_d_ready,   w_d_ready_nxt;
  logic [63:0]        r_d_rdata,   w_d_rdata_nxt;

  // Sub-word address bits are don't-care; the parameter is only consumed by the timeout.
  logic w_unused;
  assign w_unused = ^{i_if_addr[1:0], i_d_addr[2:0], (TIMEOUT_CYCLES == 0)};

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TmoW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [TmoW-1:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic            r_if_err,  w_if_err_nxt;
  logic            r_d_err,   w_d_err_nxt;
  logic            w_tmo_hit;

  // Counter holds the number of BUSY cycles already spent; this cycle is the last allowed.
  assign w_tmo_hit = (r_tmo_cnt == TmoW'(TIMEOUT_CYCLES - 1));
  assign o_if_err  = r_if_err;
  assign o_d_err   = r_d_err;
`else
  assign o_if_err  = 1'b0;
  assign o_d_err   = 1'b0;
`endif

  // Next-state: arbitration in IDLE, handshake in BUSY, single response cycle in RESP.
  always_comb begin
    w_state_nxt     = r_state;
    w_streak_nxt    = r_streak;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_wmask_nxt = r_mem_wmask;
    w_if_sel_hi_nxt = r_if_sel_hi;
    w_if_ready_nxt  = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_ready_nxt   = 1'b0;
    w_d_rdata_nxt   = r_d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
    w_tmo_cnt_nxt   = r_tmo_cnt;
    w_if_err_nxt    = r_if_err;
    w_d_err_nxt     = r_d_err;
`endif

    case (r_state)
      StIdle: begin
`ifdef MEM_ARB_TIMEOUT_EN
        w_tmo_cnt_nxt = '0;
`endif
        if (i_d_req && !(i_if_req && (r_streak == StreakMax))) begin
          w_state_nxt     = StBusyD;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = i_d_we;
          w_mem_addr_nxt  = {i_d_addr[63:3], 3'b000};
          w_mem_wdata_nxt = i_d_wdata;
          w_mem_wmask_nxt = i_d_we ? i_d_wmask : 8'h00;
          // Only contested wins count; the guard above keeps this from passing the limit.
          if (i_if_req) begin
            w_streak_nxt = r_streak + StreakW'(1);
          end
        end else if (i_if_req) begin
          w_state_nxt     = StBusyI;
          w_mem_req_nxt   = 1'b1;
          w_mem_we_nxt    = 1'b0;
          w_mem_addr_nxt  = {i_if_addr[63:3], 3'b000};
          w_mem_wdata_nxt = '0;
          w_mem_wmask_nxt = 8'h00;
          w_if_sel_hi_nxt = i_if_addr[2];
          w_streak_nxt    = '0;
        end
      end

      StBusyI, StBusyD: begin
        if (i_mem_ack) begin
          w_state_nxt   = StResp;
          w_mem_req_nxt = 1'b0;
          if (r_state == StBusyI) begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = r_if_sel_hi ? i_mem_rdata[63:32] : i_mem_rdata[31:0];
          end else begin
            w_d_ready_nxt = 1'b1;
            w_d_rdata_nxt = r_mem_we ? 64'd0 : i_mem_rdata;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          w_if_err_nxt = 1'b0;
          w_d_err_nxt  = 1'b0;
        end else if (w_tmo_hit) begin
          w_state_nxt   = StResp;
          w_mem_req_nxt = 1'b0;
          if (r_state == StBusyI) begin
            w_if_ready_nxt = 1'b1;
            w_if_rdata_nxt = '0;
            w_if_err_nxt   = 1'b1;
            w_d_err_nxt    = 1'b0;
          end else begin
            w_d_ready_nxt = 1'b1;
            w_d_rdata_nxt = '0;
            w_d_err_nxt   = 1'b1;
            w_if_err_nxt  = 1'b0;
          end
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TmoW'(1);
`endif
        end
      end

      StResp: begin
        // Requests are deliberately not sampled here; they are re-evaluated in IDLE.
        w_state_nxt = StIdle;
      end

      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_streak    <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_if_sel_hi <= 1'b0;
      r_if_ready  <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ready   <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_streak    <= w_streak_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_wmask <= w_mem_wmask_nxt;
      r_if_sel_hi <= w_if_sel_hi_nxt;
      r_if_ready  <= w_if_ready_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_ready   <= w_d_ready_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Timeout counter and error flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tmo_cnt <= '0;
      r_if_err  <= 1'b0;
      r_d_err   <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_if_err  <= w_if_err_nxt;
      r_d_err   <= w_d_err_nxt;
    end
  end
`endif

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_wmask = r_mem_wmask;
  assign o_if_ready  = r_if_ready;
  assign o_if_rdata  = r_if_rdata;
  assign o_d_ready   = r_d_ready;
  assign o_d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model of the arbiter.
module tb_mem_port_arbiter;

  localparam int MaxStreak = 4;
  localparam int Tmo       = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic [7:0]  d_wmask;
  logic        d_ready;
  logic [63:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;

  mem_port_arbiter #(
    .MAX_D_STREAK  (MaxStreak),
    .TIMEOUT_CYCLES(Tmo)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_if_req   (if_req),
    .i_if_addr  (if_addr),
    .o_if_ready (if_ready),
    .o_if_rdata (if_rdata),
    .o_if_err   (if_err),
    .i_d_req    (d_req),
    .i_d_we     (d_we),
    .i_d_addr   (d_addr),
    .i_d_wdata  (d_wdata),
    .i_d_wmask  (d_wmask),
    .o_d_ready  (d_ready),
    .o_d_rdata  (d_rdata),
    .o_d_err    (d_err),
    .o_mem_req  (mem_req),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_wmask(mem_wmask),
    .i_mem_ack  (mem_ack),
    .i_mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, timing expressed in clock-edge numbers.
  int          edge_n     = 0;
  bit          m_busy     = 1'b0;
  bit          m_side_d   = 1'b0;
  int          grant_edge = -10;
  int          ack_edge   = -10;
  int          ack_at     = 0;
  int          busy_edges = 0;
  int          streak     = 0;
  logic        t_we;
  logic [63:0] t_addr;
  logic [63:0] t_wdata;
  logic [7:0]  t_wmask;
  bit          i_done     = 1'b0;
  bit          d_done     = 1'b0;
  byte         grant_log[$];

  // Stimulus controls
  int          ack_dly    = -1;
  bit          ack_en     = 1'b1;
  bit          auto_req   = 1'b0;
  bit          hold_req   = 1'b0;
  bit          spur_en    = 1'b0;
  bit          rand_rst   = 1'b0;
  bit          use_fixed  = 1'b0;
  logic [63:0] fixed_data = 64'd0;

  task automatic check_busy();
    check_eq("mem_req", mem_req, 1'b1);
    check_eq("mem_we", mem_we, t_we);
    check_eq("mem_addr", mem_addr, {t_addr[63:3], 3'b000});
    check_eq("mem_wmask", mem_wmask, t_we ? t_wmask : 8'h00);
    if (t_we) check_eq("mem_wdata", mem_wdata, t_wdata);
    check_eq("busy_ready", {if_ready, d_ready}, 2'b00);
  endtask

  task automatic complete_txn(input bit abort, input logic [63:0] rd);
    m_busy   = 1'b0;
    ack_edge = edge_n;
    check_eq("done_mem_req", mem_req, 1'b0);
    if (m_side_d) begin
      d_done = 1'b1;
      check_eq("d_ready", {if_ready, d_ready}, 2'b01);
      check_eq("d_rdata", d_rdata, (abort || t_we) ? 64'd0 : rd);
      check_eq("d_err", d_err, abort);
    end else begin
      i_done = 1'b1;
      check_eq("if_ready", {if_ready, d_ready}, 2'b10);
      check_eq("if_rdata", if_rdata,
               abort ? 64'd0 : (t_addr[2] ? {32'd0, rd[63:32]} : {32'd0, rd[31:0]}));
      check_eq("if_err", if_err, abort);
    end
  endtask

  // Advance one clock, then compare DUT outputs with what the model predicts.
  task automatic step();
    logic        s_rst, s_ifr, s_dr, s_dwe, s_ack;
    logic [63:0] s_ifa, s_da, s_dwd, s_rd;
    logic [7:0]  s_dm;
    bit          pick_d;
    s_rst = rst;   s_ifr = if_req; s_ifa = if_addr;
    s_dr  = d_req; s_dwe = d_we;   s_da  = d_addr; s_dwd = d_wdata; s_dm = d_wmask;
    s_ack = mem_ack; s_rd = mem_rdata;
    @(posedge clk);
    #1;
    edge_n++;
    i_done = 1'b0;
    d_done = 1'b0;
    if (s_rst) begin
      m_busy   = 1'b0;
      ack_edge = edge_n - 1;
      streak   = 0;
      check_eq("rst_mem_ctl", {mem_req, mem_we, mem_wmask}, 64'd0);
      check_eq("rst_mem_addr", mem_addr, 64'd0);
      check_eq("rst_mem_wdata", mem_wdata, 64'd0);
      check_eq("rst_if", {if_ready, if_err, if_rdata}, 64'd0);
      check_eq("rst_d_ctl", {d_ready, d_err}, 64'd0);
      check_eq("rst_d_rdata", d_rdata, 64'd0);
    end else if (m_busy) begin
      busy_edges++;
      if (s_ack) complete_txn(1'b0, s_rd);
`ifdef MEM_ARB_TIMEOUT_EN
      else if (busy_edges == Tmo) complete_txn(1'b1, 64'd0);
`endif
      else check_busy();
    end else if (edge_n >= ack_edge + 2 && (s_ifr || s_dr)) begin
      pick_d = s_dr && !(s_ifr && streak == MaxStreak);
      if (pick_d) begin
        if (s_ifr) streak = (streak + 1 > MaxStreak) ? MaxStreak : streak + 1;
        t_we = s_dwe; t_addr = s_da; t_wdata = s_dwd; t_wmask = s_dm;
      end else begin
        streak = 0;
        t_we = 1'b0; t_addr = s_ifa; t_wdata = 64'd0; t_wmask = 8'h00;
      end
      m_side_d   = pick_d;
      m_busy     = 1'b1;
      grant_edge = edge_n;
      busy_edges = 0;
      ack_at     = edge_n + 1 + ((ack_dly >= 0) ? ack_dly : $urandom_range(0, 3));
      grant_log.push_back(pick_d ? 8'h44 : 8'h49);
      check_busy();
    end else begin
      check_eq("idle_mem_req", mem_req, 1'b0);
      check_eq("idle_ready", {if_ready, d_ready}, 2'b00);
    end
  endtask

  // Requester and memory behaviour for the next clock edge.
  task automatic drive();
    if (i_done && !hold_req) if_req = 1'b0;
    if (d_done && !hold_req) d_req = 1'b0;
    if (auto_req) begin
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = {$urandom, $urandom} & ~64'h3;
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req   = 1'b1;
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = {$urandom, $urandom};
        d_wdata = {$urandom, $urandom};
        d_wmask = 8'($urandom);
      end
    end
    mem_ack   = 1'b0;
    mem_rdata = {$urandom, $urandom};
    if (m_busy) begin
      if (ack_en && edge_n + 1 == ack_at) begin
        mem_ack = 1'b1;
        if (use_fixed) mem_rdata = fixed_data;
      end
    end else if (spur_en && $urandom_range(0, 5) == 0) begin
      mem_ack = 1'b1;
    end
    rst = rand_rst && ($urandom_range(0, 299) == 0);
  endtask

  initial begin
    bit    seen;
    int    n_done;
    int    g;
    int    rises[$];
    logic  prev_req;
    string exp_order;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; mem_ack = 1'b0; mem_rdata = '0;
    step();
    step();
    rst = 1'b0;

    // Single fetch from the upper half of a word
    if_req = 1'b1; if_addr = 64'h104; ack_dly = 1;
    use_fixed = 1'b1; fixed_data = 64'hAAAA5555_12345678;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (m_busy && grant_edge == edge_n) check_eq("t1_mem_addr", mem_addr, 64'h100);
      if (i_done) begin
        seen = 1'b1;
        check_eq("t1_if_rdata", if_rdata, 64'hAAAA5555);
      end
      drive();
    end
    check_eq("t1_served", seen, 1'b1);
    use_fixed = 1'b0;
    step(); drive();

    // Masked write
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h208;
    d_wdata = 64'h11223344_55667788; d_wmask = 8'h0F;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (m_busy && grant_edge == edge_n) check_eq("t2_mem_ctl", {mem_we, mem_wmask}, 9'h10F);
      if (d_done) begin
        seen = 1'b1;
        check_eq("t2_d_rdata", d_rdata, 64'd0);
      end
      drive();
    end
    check_eq("t2_served", seen, 1'b1);
    step(); drive();

    // Continuous contention with 1-cycle acks
    rst = 1'b1; step(); rst = 1'b0;
    hold_req = 1'b1; ack_dly = 0; grant_log.delete();
    if_req = 1'b1; if_addr = 64'h300; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
    for (int i = 0; i < 80; i++) begin
      step();
      check_eq("t3_one_ready", if_ready & d_ready, 1'b0);
      if (grant_log.size() >= 10) hold_req = 1'b0;
      drive();
      if (!if_req && !d_req && !m_busy) break;
    end
    hold_req = 1'b0;
    exp_order = "DDDDIDDDDI";
    check_eq("t3_grants", grant_log.size() >= 10, 1'b1);
    if (grant_log.size() >= 10) begin
      for (int i = 0; i < 10; i++) check_eq("t3_order", grant_log[i], exp_order[i]);
    end

    // Back-to-back fetches re-issued the cycle after each ready
    if_req = 1'b1; if_addr = 64'h0; n_done = 0; prev_req = mem_req; rises.delete();
    for (int i = 0; i < 14; i++) begin
      step();
      if (mem_req && !prev_req) rises.push_back(edge_n);
      prev_req = mem_req;
      if (i_done) n_done++;
      drive();
      if (i_done && n_done < 3) begin
        if_req  = 1'b1;
        if_addr = 64'(n_done * 4);
      end
    end
    check_eq("t4_readies", n_done, 3);
    check_eq("t4_rises", rises.size(), 3);
    if (rises.size() == 3) begin
      check_eq("t4_gap1", rises[1] - rises[0], 3);
      check_eq("t4_gap2", rises[2] - rises[1], 3);
    end

    // Reset while a data access is outstanding
    ack_en = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
    for (int i = 0; i < 5 && !m_busy; i++) begin
      step(); drive();
    end
    step(); drive();
    step(); drive();
    rst = 1'b1;
    step();
    check_eq("t5_mem_req", mem_req, 1'b0);
    check_eq("t5_no_d_ready", d_ready, 1'b0);
    rst = 1'b0; ack_en = 1'b1; seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (d_done) seen = 1'b1;
      drive();
    end
    check_eq("t5_served_after_rst", seen, 1'b1);

    // Memory never acknowledges
    ack_en = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h80; g = -1;
    for (int i = 0; i < 5 && g < 0; i++) begin
      step();
      if (m_busy && grant_edge == edge_n) g = edge_n;
      drive();
    end
`ifdef MEM_ARB_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 0; i < 15 && !seen; i++) begin
      step();
      if (d_done) begin
        seen = 1'b1;
        check_eq("t6_busy_len", edge_n - g, Tmo);
        check_eq("t6_d_err", d_err, 1'b1);
      end
      drive();
    end
    check_eq("t6_done", seen, 1'b1);
    mem_ack = 1'b1;
    step();
    check_eq("t6_late_ack", d_ready, 1'b0);
    drive();
`else
    repeat (20) begin
      step(); drive();
    end
    check_eq("t6_req_held", mem_req, 1'b1);
    mem_ack = 1'b1;
    step();
    check_eq("t6_manual_ack", d_done, 1'b1);
    drive();
`endif
    ack_en = 1'b1;

    // Randomized traffic with spurious acks and occasional resets
    auto_req = 1'b1; spur_en = 1'b1; rand_rst = 1'b1; ack_dly = -1;
    repeat (3000) begin
      step(); drive();
    end
    auto_req = 1'b0; rand_rst = 1'b0; rst = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!if_req && !d_req && !m_busy) break;
      step(); drive();
    end
    check_eq("drain", {if_req, d_req, m_busy}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
